// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: address-field widths and the FSM state type.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP,
        S_REQ,
        S_WAIT,
        S_FILL_DONE
    } state_t;

    function automatic int off_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int word_bits(input int line_bytes);
        return $clog2(line_bytes / 4);
    endfunction

    function automatic int idx_bits(input int cache_size, input int line_bytes, input int num_ways);
        return $clog2(cache_size / (line_bytes * num_ways));
    endfunction

    function automatic int tag_bits(input int cache_size, input int line_bytes, input int num_ways);
        return 32 - off_bits(line_bytes) - idx_bits(cache_size, line_bytes, num_ways);
    endfunction

endpackage

// File: rtl/icache_xwa_if.sv
// Fetch-port and memory-port bundle of the instruction cache.
interface icache_xwa_if;
    // Handshakes: proc_valid is held by the requester until the one-cycle proc_ready strobe;
    // mem_req_valid/addr are held by the cache until the one-cycle mem_req_ready strobe.
    logic        proc_valid;
    logic        proc_ready;
    logic [31:0] proc_addr;
    logic [31:0] proc_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_rdata;
    logic        debug_miss;
    logic [31:0] occupancy;

    modport slave (
        input  proc_valid, proc_addr, mem_req_ready, mem_req_rdata,
        output proc_ready, proc_rdata, mem_req_valid, mem_req_addr, debug_miss, occupancy
    );

    modport master (
        output proc_valid, proc_addr, mem_req_ready, mem_req_rdata,
        input  proc_ready, proc_rdata, mem_req_valid, mem_req_addr, debug_miss, occupancy
    );
endinterface

// File: rtl/icache_way_array.sv
// Per-way valid/tag/data storage; combinational read of one set, one word or tag write per cycle.
module icache_way_array #(
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 64,
    parameter int NUM_BLOCKS = 4,
    parameter int TAG_W      = 22,
    parameter int IDX_W      = $clog2(NUM_SETS),
    parameter int WORD_W     = $clog2(NUM_BLOCKS),
    parameter int WAY_W      = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_W-1:0]    i_idx,
    input  logic [WORD_W-1:0]   i_rd_word,
    output logic [NUM_WAYS-1:0] o_valid,
    output logic [TAG_W-1:0]    o_tag  [NUM_WAYS],
    output logic [31:0]         o_word [NUM_WAYS],
    input  logic [WAY_W-1:0]    i_wr_way,
    input  logic                i_wr_word_en,
    input  logic [WORD_W-1:0]   i_wr_word,
    input  logic [31:0]         i_wr_data,
    input  logic                i_wr_tag_en,
    input  logic [TAG_W-1:0]    i_wr_tag
);

    logic [NUM_SETS-1:0] r_valid [NUM_WAYS];
    logic [TAG_W-1:0]    r_tag   [NUM_WAYS][NUM_SETS];
    logic [31:0]         r_data  [NUM_WAYS][NUM_SETS][NUM_BLOCKS];

    // Only the valid bits need reset; stale tags/data are unreachable while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                r_valid[w] <= '0;
            end
        end else if (i_wr_tag_en) begin
            r_valid[i_wr_way][i_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_tag_en) begin
            r_tag[i_wr_way][i_idx] <= i_wr_tag;
        end
        if (i_wr_word_en) begin
            r_data[i_wr_way][i_idx][i_wr_word] <= i_wr_data;
        end
    end

    for (genvar gw = 0; gw < NUM_WAYS; gw++) begin : g_rd
        assign o_valid[gw] = r_valid[gw][i_idx];
        assign o_tag[gw]   = r_tag[gw][i_idx];
        assign o_word[gw]  = r_data[gw][i_idx][i_rd_word];
    end

endmodule

// File: rtl/icache_xwa.sv
// Read-only N-way set-associative instruction cache with word-by-word line refill
// and round-robin replacement once a set is full.
module icache_xwa
    import icache_pkg::*;
#(
    parameter int CACHE_SIZE = 4096,
    parameter int NUM_WAYS   = 4,
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4
) (
    input  logic         clk,
    input  logic         reset,
    icache_xwa_if.slave  bus,
    output state_t       o_state
);

    localparam int LINE_BYTES = NUM_BLOCKS * BLOCK_SIZE;
    localparam int OFF_W      = off_bits(LINE_BYTES);
    localparam int WORD_W     = word_bits(LINE_BYTES);
    localparam int IDX_W      = idx_bits(CACHE_SIZE, LINE_BYTES, NUM_WAYS);
    localparam int TAG_W      = tag_bits(CACHE_SIZE, LINE_BYTES, NUM_WAYS);
    localparam int NUM_SETS   = 1 << IDX_W;
    localparam int WAY_W      = $clog2(NUM_WAYS);
    localparam int NUM_LINES  = NUM_SETS * NUM_WAYS;

    state_t            r_state;
    logic [31:2]       r_addr;
    logic              r_ready;
    logic [31:0]       r_rdata;
    logic              r_mem_valid;
    logic [31:0]       r_mem_addr;
    logic              r_miss;
    logic [31:0]       r_occ;
    logic [WAY_W-1:0]  r_victim;
    logic              r_victim_new;
    logic [WORD_W-1:0] r_cnt;
    logic [WAY_W-1:0]  r_rr [NUM_SETS];

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WORD_W-1:0]   w_word;
    logic [NUM_WAYS-1:0] w_valid;
    logic [TAG_W-1:0]    w_tag_rd  [NUM_WAYS];
    logic [31:0]         w_word_rd [NUM_WAYS];
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic                w_any_inv;
    logic [WAY_W-1:0]    w_inv_way;

    assign w_idx  = r_addr[OFF_W +: IDX_W];
    assign w_tag  = r_addr[31 -: TAG_W];
    assign w_word = r_addr[2 +: WORD_W];

    icache_way_array #(
        .NUM_WAYS   (NUM_WAYS),
        .NUM_SETS   (NUM_SETS),
        .NUM_BLOCKS (NUM_BLOCKS),
        .TAG_W      (TAG_W)
    ) u_ways (
        .clk          (clk),
        .reset        (reset),
        .i_idx        (w_idx),
        .i_rd_word    (w_word),
        .o_valid      (w_valid),
        .o_tag        (w_tag_rd),
        .o_word       (w_word_rd),
        .i_wr_way     (r_victim),
        .i_wr_word_en (r_state == S_WAIT && bus.mem_req_ready),
        .i_wr_word    (r_cnt),
        .i_wr_data    (bus.mem_req_rdata),
        .i_wr_tag_en  (r_state == S_FILL_DONE),
        .i_wr_tag     (w_tag)
    );

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_any_inv = 1'b0;
        w_inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (w_valid[w] && w_tag_rd[w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_valid[w]) begin
                w_any_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_ready      <= 1'b0;
            r_rdata      <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_miss       <= 1'b0;
            r_occ        <= '0;
            r_victim     <= '0;
            r_victim_new <= 1'b0;
            r_cnt        <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            r_ready <= 1'b0;
            r_miss  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.proc_valid) begin
                        r_addr  <= bus.proc_addr[31:2];
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_rdata <= w_word_rd[w_hit_way];
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_miss       <= 1'b1;
                        r_cnt        <= '0;
                        r_victim_new <= w_any_inv;
                        r_victim     <= w_any_inv ? w_inv_way : r_rr[w_idx];
                        r_state      <= S_REQ;
                    end
                end
                S_RESP: r_state <= S_IDLE;
                S_REQ: begin
                    r_mem_valid <= 1'b1;
                    r_mem_addr  <= {w_tag, w_idx, r_cnt, 2'b00};
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_req_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_cnt == WORD_W'(NUM_BLOCKS - 1)) begin
                            r_state <= S_FILL_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_FILL_DONE: begin
                    if (r_victim_new) begin
                        if (r_occ < 32'(NUM_LINES)) r_occ <= r_occ + 32'd1;
                    end else begin
                        r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
                    end
                    r_state <= S_LOOKUP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.proc_ready    = r_ready;
    assign bus.proc_rdata    = r_rdata;
    assign bus.mem_req_valid = r_mem_valid;
    assign bus.mem_req_addr  = r_mem_addr;
    assign bus.debug_miss    = r_miss;
    assign bus.occupancy     = r_occ;
    assign o_state           = r_state;

endmodule

// File: tb/tb_icache_xwa.sv
// Self-checking bench for icache_xwa: random fetch streams checked against a per-set FIFO model.
module tb_icache_xwa;
    import icache_pkg::*;

    localparam int NUM_BLOCKS = 4;
    localparam int NUM_WAYS   = 4;
    localparam int NUM_SETS   = 64;

    logic   clk = 1'b0;
    logic   reset;
    state_t dbg_state;

    always #5 clk = ~clk;

    icache_xwa_if bus ();

    icache_xwa #(
        .CACHE_SIZE (4096),
        .NUM_WAYS   (NUM_WAYS),
        .NUM_BLOCKS (NUM_BLOCKS),
        .BLOCK_SIZE (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mem_delay = 0;

    int          obs_lat;
    int          obs_miss;
    int          obs_rises;
    int          obs_unstable;
    logic [31:0] obs_rdata;
    logic [31:0] obs_addr_q[$];
    logic [31:0] exp_q[$];

    // Reference model: a set never loses lines, so replacement is oldest-first per set.
    logic [27:0] m_line [NUM_SETS][NUM_WAYS];
    int          m_cnt  [NUM_SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic int model_occ();
        int sum = 0;
        for (int s = 0; s < NUM_SETS; s++) sum += m_cnt[s];
        return sum;
    endfunction

    task automatic model_access(input logic [31:0] addr, output bit hit);
        logic [27:0] line = addr[31:4];
        int s = int'(line % NUM_SETS);
        hit = 1'b0;
        for (int i = 0; i < m_cnt[s]; i++) if (m_line[s][i] == line) hit = 1'b1;
        if (!hit) begin
            if (m_cnt[s] < NUM_WAYS) begin
                m_line[s][m_cnt[s]] = line;
                m_cnt[s]++;
            end else begin
                for (int i = 0; i < NUM_WAYS - 1; i++) m_line[s][i] = m_line[s][i + 1];
                m_line[s][NUM_WAYS - 1] = line;
            end
        end
    endtask

    always @(negedge clk) begin : mem_responder
        static int wait_cnt = 0;
        if (reset) begin
            bus.mem_req_ready = 1'b0;
            wait_cnt = 0;
        end else if (bus.mem_req_ready) begin
            bus.mem_req_ready = 1'b0;
        end else if (bus.mem_req_valid) begin
            if (wait_cnt >= mem_delay) begin
                bus.mem_req_ready = 1'b1;
                bus.mem_req_rdata = mem_word(bus.mem_req_addr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic apply_reset();
        bus.proc_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < NUM_SETS; s++) m_cnt[s] = 0;
    endtask

    // Drives one fetch and records what the bus did; obs_lat stays -1 on timeout.
    task automatic do_fetch(input logic [31:0] addr);
        logic        prev_v;
        logic [31:0] prev_a;
        obs_lat = -1; obs_miss = 0; obs_rises = 0; obs_unstable = 0;
        obs_rdata = '0;
        obs_addr_q.delete();
        @(negedge clk);
        bus.proc_valid = 1'b1;
        bus.proc_addr  = addr;
        prev_v = bus.mem_req_valid;
        prev_a = bus.mem_req_addr;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk); #1;
            if (cyc == 1) bus.proc_addr = $urandom;
            if (bus.debug_miss) obs_miss++;
            if (bus.mem_req_valid && !prev_v) begin
                obs_rises++;
                obs_addr_q.push_back(bus.mem_req_addr);
            end
            if (bus.mem_req_valid && prev_v && bus.mem_req_addr !== prev_a) obs_unstable++;
            prev_v = bus.mem_req_valid;
            prev_a = bus.mem_req_addr;
            if (bus.proc_ready) begin
                obs_lat   = cyc;
                obs_rdata = bus.proc_rdata;
                break;
            end
        end
        bus.proc_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (bus.proc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_proc_ready: got %0b expected 0", bus.proc_ready); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %0b expected 0", bus.mem_req_valid); end
        n_checks++; if (bus.debug_miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %0b expected 0", bus.debug_miss); end
        n_checks++; if (bus.proc_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %0h expected 0", bus.proc_rdata); end
        n_checks++; if (bus.mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_req_addr); end
        n_checks++; if (bus.occupancy !== 32'h0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_cold_miss();
        bit hit;
        bit seq_ok;
        mem_delay = 0;
        model_access(32'h100, hit);
        do_fetch(32'h100);
        exp_q.delete();
        for (int i = 0; i < NUM_BLOCKS; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        seq_ok = (obs_addr_q.size() == exp_q.size());
        if (seq_ok) foreach (exp_q[i]) if (obs_addr_q[i] !== exp_q[i]) seq_ok = 1'b0;
        n_checks++; if (obs_miss != 1) begin n_fail++; $display("FAIL cold_miss_pulse: got %0d expected 1", obs_miss); end
        n_checks++; if (!seq_ok) begin n_fail++; $display("FAIL cold_addr_seq: got %p expected %p", obs_addr_q, exp_q); end
        n_checks++; if (obs_rdata !== 32'hA0) begin n_fail++; $display("FAIL cold_rdata: got %0h expected a0", obs_rdata); end
        n_checks++; if (obs_lat != 4 + NUM_BLOCKS * 2) begin n_fail++; $display("FAIL cold_latency: got %0d expected %0d", obs_lat, 4 + NUM_BLOCKS * 2); end
        n_checks++; if (bus.occupancy !== 32'(model_occ())) begin n_fail++; $display("FAIL cold_occupancy: got %0d expected %0d", bus.occupancy, model_occ()); end
    endtask

    task automatic test_hit();
        bit hit;
        model_access(32'h108, hit);
        do_fetch(32'h108);
        n_checks++; if (obs_rises != 0) begin n_fail++; $display("FAIL hit_mem_req: got %0d expected 0", obs_rises); end
        n_checks++; if (obs_miss != 0) begin n_fail++; $display("FAIL hit_miss_pulse: got %0d expected 0", obs_miss); end
        n_checks++; if (obs_lat != 2) begin n_fail++; $display("FAIL hit_latency: got %0d expected 2", obs_lat); end
        n_checks++; if (obs_rdata !== 32'hA2) begin n_fail++; $display("FAIL hit_rdata: got %0h expected a2", obs_rdata); end
    endtask

    task automatic test_set_conflict();
        logic [31:0] seq [7] = '{32'h0, 32'h400, 32'h800, 32'hC00, 32'h1000, 32'h400, 32'h0};
        bit hit;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            model_access(seq[i], hit);
            do_fetch(seq[i]);
            n_checks++; if (obs_miss != (hit ? 0 : 1)) begin n_fail++; $display("FAIL conflict_miss[%0d]: got %0d expected %0d", i, obs_miss, hit ? 0 : 1); end
            n_checks++; if (obs_rdata !== mem_word(seq[i])) begin n_fail++; $display("FAIL conflict_rdata[%0d]: got %0h expected %0h", i, obs_rdata, mem_word(seq[i])); end
            n_checks++; if (bus.occupancy !== 32'(model_occ())) begin n_fail++; $display("FAIL conflict_occ[%0d]: got %0d expected %0d", i, bus.occupancy, model_occ()); end
        end
    endtask

    task automatic test_slow_mem();
        logic [31:0] a = 32'h2344;
        bit hit;
        bit seq_ok;
        mem_delay = 5;
        model_access(a, hit);
        do_fetch(a);
        exp_q.delete();
        for (int i = 0; i < NUM_BLOCKS; i++) exp_q.push_back(32'h2340 + 32'(4 * i));
        seq_ok = (obs_addr_q.size() == exp_q.size());
        if (seq_ok) foreach (exp_q[i]) if (obs_addr_q[i] !== exp_q[i]) seq_ok = 1'b0;
        n_checks++; if (obs_rises != NUM_BLOCKS) begin n_fail++; $display("FAIL slow_rises: got %0d expected %0d", obs_rises, NUM_BLOCKS); end
        n_checks++; if (obs_unstable != 0) begin n_fail++; $display("FAIL slow_stable: got %0d changes expected 0", obs_unstable); end
        n_checks++; if (!seq_ok) begin n_fail++; $display("FAIL slow_addr_seq: got %p expected %p", obs_addr_q, exp_q); end
        n_checks++; if (obs_rdata !== mem_word(a)) begin n_fail++; $display("FAIL slow_rdata: got %0h expected %0h", obs_rdata, mem_word(a)); end
        n_checks++; if (obs_lat != 4 + NUM_BLOCKS * 7) begin n_fail++; $display("FAIL slow_latency: got %0d expected %0d", obs_lat, 4 + NUM_BLOCKS * 7); end
        mem_delay = 0;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] a = 32'h3F88;
        int words = 0;
        bit armed = 1'b0;
        bit hit;
        mem_delay = 4;
        @(negedge clk);
        bus.proc_valid = 1'b1;
        bus.proc_addr  = a;
        for (int c = 0; c < 500 && !armed; c++) begin
            @(negedge clk); #1;
            if (bus.mem_req_ready) words++;
            if (words == 2 && bus.mem_req_valid && !bus.mem_req_ready) armed = 1'b1;
        end
        n_checks++; if (!armed) begin n_fail++; $display("FAIL midfill_third_req: got %0d words expected 2 then a pending request", words); end
        reset = 1'b1;
        bus.proc_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midfill_mem_valid: got %0b expected 0", bus.mem_req_valid); end
        n_checks++; if (bus.occupancy !== 32'h0) begin n_fail++; $display("FAIL midfill_occupancy: got %0d expected 0", bus.occupancy); end
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < NUM_SETS; s++) m_cnt[s] = 0;
        mem_delay = 0;
        model_access(a, hit);
        do_fetch(a);
        n_checks++; if (obs_miss != 1) begin n_fail++; $display("FAIL midfill_refetch_miss: got %0d expected 1", obs_miss); end
        n_checks++; if (obs_rdata !== mem_word(a)) begin n_fail++; $display("FAIL midfill_rdata: got %0h expected %0h", obs_rdata, mem_word(a)); end
        n_checks++; if (bus.occupancy !== 32'h1) begin n_fail++; $display("FAIL midfill_occ_after: got %0d expected 1", bus.occupancy); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit hit;
        int exp_lat;
        for (int i = 0; i < 150; i++) begin
            a = $urandom_range(0, 32'h2FFF);
            mem_delay = $urandom_range(0, 3);
            model_access(a, hit);
            exp_lat = hit ? 2 : 4 + NUM_BLOCKS * (2 + mem_delay);
            do_fetch(a);
            n_checks++; if (obs_miss != (hit ? 0 : 1)) begin n_fail++; $display("FAIL rand_miss[%0d]: addr %0h got %0d expected %0d", i, a, obs_miss, hit ? 0 : 1); end
            n_checks++; if (obs_lat != exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: addr %0h got %0d expected %0d", i, a, obs_lat, exp_lat); end
            n_checks++; if (obs_rdata !== mem_word({a[31:2], 2'b00})) begin n_fail++; $display("FAIL rand_rdata[%0d]: addr %0h got %0h expected %0h", i, a, obs_rdata, mem_word({a[31:2], 2'b00})); end
            n_checks++; if (bus.occupancy !== 32'(model_occ())) begin n_fail++; $display("FAIL rand_occ[%0d]: got %0d expected %0d", i, bus.occupancy, model_occ()); end
        end
        mem_delay = 0;
    endtask

    task automatic test_stream();
        logic [31:0] a;
        bit hit;
        int misses;
        apply_reset();
        mem_delay = 0;
        for (int pass = 0; pass < 2; pass++) begin
            misses = 0;
            for (int i = 0; i < 256; i++) begin
                a = 32'(i * 16) + $urandom_range(0, 15);
                model_access(a, hit);
                do_fetch(a);
                misses += obs_miss;
                n_checks++; if (obs_rdata !== mem_word({a[31:2], 2'b00})) begin n_fail++; $display("FAIL stream_rdata[%0d/%0d]: got %0h expected %0h", pass, i, obs_rdata, mem_word({a[31:2], 2'b00})); end
            end
            n_checks++; if (misses != (pass == 0 ? 256 : 0)) begin n_fail++; $display("FAIL stream_misses[%0d]: got %0d expected %0d", pass, misses, pass == 0 ? 256 : 0); end
            n_checks++; if (bus.occupancy !== 32'd256) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d expected 256", pass, bus.occupancy); end
        end
    endtask

    initial begin
        bus.proc_valid = 1'b0;
        bus.proc_addr  = '0;
        reset = 1'b1;
        test_reset();
        test_cold_miss();
        test_hit();
        test_set_conflict();
        test_slow_mem();
        test_reset_mid_refill();
        test_random();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
